riscv_mmio_bridge: RTL and testbench

Parametrised memory-mapped I/O bridge between the core's data-memory port and on-board peripherals. It decodes a 256-byte I/O window and serves a debounced switch register, a byte-writable LED register, a prescaled 32-bit timer with compare, and sticky status/interrupt logic. Non-I/O accesses pass through to the external data cache.

---
 rtl/riscv_mmio_bridge.sv | 193 +++++++++++++++++++
 tb/tb_riscv_mmio_bridge.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/riscv_mmio_bridge.sv
// riscv_mmio_bridge
//   Memory-mapped I/O bridge between the core data-memory port and the
//   on-board peripherals. A 256-byte window at IO_BASE holds a debounced
//   switch register, a byte-writable LED register, a prescaled 32-bit timer
//   with compare, and sticky status / interrupt-enable registers. Every other
//   address passes through to the external data cache.
//
// Ports
//   clk              core clock, rising edge
//   rst              asynchronous active-low reset
//   addr             byte address from the core
//   cache_d_write_en store strobe
//   cache_d_write    store size (SB / SH / SW)
//   data_to_cache    right-aligned store data
//   mem_rdata        read data from the data cache
//   mem_write_en     store strobe forwarded to the cache (never for I/O)
//   data_out         read data to the core (I/O register or mem_rdata)
//   sw               raw asynchronous switch inputs
//   led              LED drive
//   irq              registered level interrupt

`ifndef CACHE_D_WRITE_LEN
`define CACHE_D_WRITE_LEN 2
`define CACHE_D_WRITE_SB 2'd0
`define CACHE_D_WRITE_SH 2'd1
`define CACHE_D_WRITE_SW 2'd2
`endif

module riscv_mmio_bridge #(
  parameter logic [31:0] IO_BASE         = 32'hFFFFFC00,
  parameter int          SW_W            = 24,
  parameter int          LED_W           = 24,
  parameter int          DEBOUNCE_CYCLES = 16,
  parameter int          TIMER_PRESCALE  = 1
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [31:0]                   addr,
  input  logic                          cache_d_write_en,
  input  logic [`CACHE_D_WRITE_LEN-1:0] cache_d_write,
  input  logic [31:0]                   data_to_cache,
  input  logic [31:0]                   mem_rdata,
  output logic                          mem_write_en,
  output logic [31:0]                   data_out,
  input  logic [SW_W-1:0]               sw,
  output logic [LED_W-1:0]              led,
  output logic                          irq
);

  localparam int DB_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam int PS_W = (TIMER_PRESCALE > 1) ? $clog2(TIMER_PRESCALE) : 1;
  localparam logic [DB_W-1:0] DB_MAX = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [PS_W-1:0] PS_MAX = PS_W'(TIMER_PRESCALE - 1);

  // Replace the byte lanes selected by be, keep the others.
  function automatic logic [31:0] lane_merge(input logic [31:0] old_v,
                                             input logic [3:0]  be_v,
                                             input logic [31:0] wd_v);
    logic [31:0] r;
    for (int b = 0; b < 4; b++)
      r[8*b +: 8] = be_v[b] ? wd_v[8*b +: 8] : old_v[8*b +: 8];
    return r;
  endfunction

  logic [SW_W-1:0]  sync1_q, sync2_q, sw_stable_q, sw_stable_d;
  logic [DB_W-1:0]  db_cnt_q, db_cnt_d;
  logic [PS_W-1:0]  ps_q, ps_d;
  logic [31:0]      timer_q, timer_d, cmp_q, cmp_d, timer_inc;
  logic [LED_W-1:0] led_q, led_d;
  logic [1:0]       status_q, status_d, irq_en_q, irq_en_d, hw_set, w1c;
  logic             irq_q, irq_d;

  logic        is_io, io_we, tick;
  logic [3:0]  be;
  logic [31:0] wd, rd_io;

  assign is_io        = (addr & 32'hFFFFFF00) == IO_BASE;
  assign io_we        = cache_d_write_en & is_io;
  assign mem_write_en = cache_d_write_en & ~is_io;
  assign led          = led_q;
  assign irq          = irq_q;

  // Byte enables and lane-replicated store data.
  always_comb begin
    be = 4'b0000;
    wd = data_to_cache;
    case (cache_d_write)
      `CACHE_D_WRITE_SB: begin
        be = 4'b0001 << addr[1:0];
        wd = {4{data_to_cache[7:0]}};
      end
      `CACHE_D_WRITE_SH: begin
        be = addr[1] ? 4'b1100 : 4'b0011;
        wd = {2{data_to_cache[15:0]}};
      end
      `CACHE_D_WRITE_SW: be = 4'b1111;
      default:           be = 4'b0000;
    endcase
  end

  // Combinational read mux.
  always_comb begin
    rd_io = '0;
    case (addr[7:2])
      6'h00: rd_io[SW_W-1:0]  = sw_stable_q;
      6'h01: rd_io[LED_W-1:0] = led_q;
      6'h02: rd_io            = timer_q;
      6'h03: rd_io            = cmp_q;
      6'h04: rd_io[1:0]       = status_q;
      6'h05: rd_io[1:0]       = irq_en_q;
      default: rd_io = '0;
    endcase
    data_out = is_io ? rd_io : mem_rdata;
  end

  always_comb begin
    sw_stable_d = sw_stable_q;
    db_cnt_d    = db_cnt_q;
    led_d       = led_q;
    timer_d     = timer_q;
    cmp_d       = cmp_q;
    irq_en_d    = irq_en_q;
    hw_set      = 2'b00;
    w1c         = 2'b00;
    timer_inc   = timer_q + 32'd1;
    tick        = (ps_q == PS_MAX);
    ps_d        = tick ? '0 : ps_q + PS_W'(1);

    // Whole-vector debouncer: any mismatch must persist DEBOUNCE_CYCLES
    // consecutive edges before the new vector is accepted.
    if (sync2_q == sw_stable_q) begin
      db_cnt_d = '0;
    end else if (db_cnt_q == DB_MAX) begin
      sw_stable_d = sync2_q;
      db_cnt_d    = '0;
      hw_set[1]   = 1'b1;
    end else begin
      db_cnt_d = db_cnt_q + DB_W'(1);
    end

    if (io_we && addr[7:2] == 6'h01)
      for (int i = 0; i < LED_W; i++)
        led_d[i] = be[i/8] ? wd[i] : led_q[i];

    // A CPU write to TIMER wins over a tick and never raises a match.
    if (io_we && addr[7:2] == 6'h02) begin
      timer_d = lane_merge(timer_q, be, wd);
    end else if (tick) begin
      timer_d   = timer_inc;
      hw_set[0] = (timer_inc == cmp_q);
    end

    if (io_we && addr[7:2] == 6'h03)
      cmp_d = lane_merge(cmp_q, be, wd);
    if (io_we && addr[7:2] == 6'h04 && be[0])
      w1c = wd[1:0];
    if (io_we && addr[7:2] == 6'h05 && be[0])
      irq_en_d = wd[1:0];

    // Hardware set beats a same-cycle clear.
    status_d = (status_q & ~w1c) | hw_set;
    irq_d    = |(status_q & irq_en_q);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync1_q     <= '0;
      sync2_q     <= '0;
      sw_stable_q <= '0;
      db_cnt_q    <= '0;
      ps_q        <= '0;
      timer_q     <= '0;
      cmp_q       <= 32'hFFFFFFFF;
      led_q       <= '0;
      status_q    <= '0;
      irq_en_q    <= '0;
      irq_q       <= 1'b0;
    end else begin
      sync1_q     <= sw;
      sync2_q     <= sync1_q;
      sw_stable_q <= sw_stable_d;
      db_cnt_q    <= db_cnt_d;
      ps_q        <= ps_d;
      timer_q     <= timer_d;
      cmp_q       <= cmp_d;
      led_q       <= led_d;
      status_q    <= status_d;
      irq_en_q    <= irq_en_d;
      irq_q       <= irq_d;
    end
  end

endmodule

// File: tb/tb_riscv_mmio_bridge.sv
// Directed, scoreboard-driven bench for riscv_mmio_bridge
// (DEBOUNCE_CYCLES = 4, TIMER_PRESCALE = 2, SW_W = LED_W = 24).

`ifndef CACHE_D_WRITE_LEN
`define CACHE_D_WRITE_LEN 2
`define CACHE_D_WRITE_SB 2'd0
`define CACHE_D_WRITE_SH 2'd1
`define CACHE_D_WRITE_SW 2'd2
`endif

module tb_riscv_mmio_bridge;

  localparam logic [31:0] BASE = 32'hFFFFFC00;
  localparam logic [31:0] A_SW = BASE + 32'h00, A_LED = BASE + 32'h04,
                          A_TMR = BASE + 32'h08, A_CMP = BASE + 32'h0C,
                          A_ST = BASE + 32'h10, A_IE = BASE + 32'h14;
  localparam logic [`CACHE_D_WRITE_LEN-1:0] SB = `CACHE_D_WRITE_SB,
                                            SH = `CACHE_D_WRITE_SH,
                                            SW = `CACHE_D_WRITE_SW;

  logic clk = 1'b0, rst = 1'b0;
  logic [31:0] addr = '0, data_to_cache = '0, mem_rdata = '0;
  logic cache_d_write_en = 1'b0;
  logic [`CACHE_D_WRITE_LEN-1:0] cache_d_write = SW;
  logic [23:0] sw = '0;
  logic mem_write_en, irq;
  logic [31:0] data_out;
  logic [23:0] led;

  riscv_mmio_bridge #(
    .IO_BASE(BASE), .SW_W(24), .LED_W(24),
    .DEBOUNCE_CYCLES(4), .TIMER_PRESCALE(2)
  ) dut (
    .clk(clk), .rst(rst), .addr(addr),
    .cache_d_write_en(cache_d_write_en), .cache_d_write(cache_d_write),
    .data_to_cache(data_to_cache), .mem_rdata(mem_rdata),
    .mem_write_en(mem_write_en), .data_out(data_out),
    .sw(sw), .led(led), .irq(irq)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       tag;
    logic [31:0] val;
  } exp_t;

  exp_t sb_q[$];
  int tests = 0;
  int fails = 0;
  int edges = 0;

  task automatic push(input string tag, input logic [31:0] v);
    exp_t e;
    e.tag = tag;
    e.val = v;
    sb_q.push_back(e);
  endtask

  task automatic check(input logic [31:0] obs);
    exp_t e;
    tests++;
    assert (sb_q.size() != 0) else begin
      fails++;
      $error("FAIL sb_empty: observed %h, nothing expected", obs);
    end
    if (sb_q.size() != 0) begin
      e = sb_q.pop_front();
      assert (obs === e.val) else begin
        fails++;
        $error("FAIL %s: observed %h required %h", e.tag, obs, e.val);
      end
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    edges++;
  endtask

  task automatic rd(input string tag, input logic [31:0] a, input logic [31:0] exp_v);
    addr             = a;
    cache_d_write_en = 1'b0;
    push(tag, exp_v);
    #1;
    check(data_out);
  endtask

  task automatic chk_led(input string tag, input logic [23:0] exp_v);
    push(tag, {8'h00, exp_v});
    check({8'h00, led});
  endtask

  task automatic chk_irq(input string tag, input logic exp_v);
    push(tag, {31'b0, exp_v});
    check({31'b0, irq});
  endtask

  // One store committed at the next edge; the forwarded strobe is checked first.
  task automatic wr(input logic [31:0] a, input logic [31:0] d,
                    input logic [`CACHE_D_WRITE_LEN-1:0] sz);
    logic io;
    io               = ((a & 32'hFFFFFF00) == BASE);
    addr             = a;
    data_to_cache    = d;
    cache_d_write    = sz;
    cache_d_write_en = 1'b1;
    push($sformatf("mem_we_%h", a), {31'b0, ~io});
    #1;
    check({31'b0, mem_write_en});
    step();
    cache_d_write_en = 1'b0;
  endtask

  // Ticks land on even edges after reset release (prescale 2).
  task automatic align(input bit want_tick);
    if ((((edges + 1) % 2) == 0) != want_tick) step();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(posedge clk);
    #1;
    // Reset state
    chk_led("rst_led", 24'h0);
    chk_irq("rst_irq", 1'b0);
    rd("rst_sw", A_SW, 32'h0);
    rd("rst_timer", A_TMR, 32'h0);
    rd("rst_cmp", A_CMP, 32'hFFFFFFFF);
    rd("rst_status", A_ST, 32'h0);
    rd("rst_irq_en", A_IE, 32'h0);
    rst   = 1'b1;
    edges = 0;

    // Passthrough
    wr(32'h00001000, 32'hDEADBEEF, SW);
    chk_led("pass_led", 24'h0);
    mem_rdata = 32'h12345678;
    rd("pass_rdata", 32'h00001000, 32'h12345678);
    wr(BASE + 32'h20, 32'hCAFEF00D, SW);
    rd("unmapped_rd", BASE + 32'h20, 32'h0);

    // LED lanes
    wr(A_LED, 32'hAABBCCDD, SW);
    chk_led("led_sw", 24'hBBCCDD);
    wr(BASE + 32'h06, 32'h00000011, SB);
    chk_led("led_sb2", 24'h11CCDD);
    wr(A_LED, 32'h00002233, SH);
    chk_led("led_sh0", 24'h112233);
    wr(BASE + 32'h07, 32'h00000055, SB);
    chk_led("led_sb3_drop", 24'h112233);
    rd("led_rd", A_LED, 32'h00112233);

    // Debounce: accepted exactly 2 + 4 edges after the change
    sw = 24'h000005;
    repeat (5) step();
    rd("db_sw_early", A_SW, 32'h0);
    rd("db_st_early", A_ST, 32'h0);
    step();
    rd("db_sw", A_SW, 32'h5);
    rd("db_st", A_ST, 32'h2);
    wr(A_ST, 32'h2, SW);
    rd("db_w1c", A_ST, 32'h0);
    sw = 24'h000007;
    repeat (3) step();
    sw = 24'h000005;
    repeat (10) step();
    rd("glitch_sw", A_SW, 32'h5);
    rd("glitch_st", A_ST, 32'h0);

    // IRQ_EN keeps only bits [1:0]
    wr(A_IE, 32'hFFFFFFFF, SW);
    rd("irq_en_mask", A_IE, 32'h3);

    // Timer / irq
    wr(A_CMP, 32'h3, SW);
    wr(A_IE, 32'h1, SW);
    align(1'b1);
    wr(A_TMR, 32'h0, SW);
    repeat (5) step();
    rd("tmr_st_early", A_ST, 32'h0);
    step();
    rd("tmr_st", A_ST, 32'h1);
    rd("tmr_val", A_TMR, 32'h3);
    chk_irq("tmr_irq_early", 1'b0);
    step();
    chk_irq("tmr_irq", 1'b1);
    wr(A_ST, 32'h1, SW);
    rd("w1c_st", A_ST, 32'h0);
    step();
    chk_irq("w1c_irq", 1'b0);

    // Collision: TIMER write beats a tick that would have matched
    align(1'b0);
    wr(A_TMR, 32'h2, SW);
    wr(A_TMR, 32'h3, SW);
    rd("coll_tmr", A_TMR, 32'h3);
    rd("coll_tmr_st", A_ST, 32'h0);
    // Collision: match beats a same-cycle W1C
    align(1'b0);
    wr(A_TMR, 32'h2, SW);
    wr(A_ST, 32'h1, SW);
    rd("coll_w1c_st", A_ST, 32'h1);
    step();
    chk_irq("coll_w1c_irq", 1'b1);

    // Reset mid-run
    wr(A_LED, 32'h000000FF, SW);
    wr(A_TMR, 32'd100, SW);
    chk_led("pre_rst_led", 24'h0000FF);
    rd("pre_rst_tmr", A_TMR, 32'd100);
    rst = 1'b0;
    #1;
    chk_led("mid_rst_led", 24'h0);
    chk_irq("mid_rst_irq", 1'b0);
    rd("mid_rst_tmr", A_TMR, 32'h0);
    rd("mid_rst_cmp", A_CMP, 32'hFFFFFFFF);
    rd("mid_rst_st", A_ST, 32'h0);
    rd("mid_rst_sw", A_SW, 32'h0);
    @(posedge clk);
    #1;
    rst   = 1'b1;
    edges = 0;
    step();
    rd("post_rst_tmr1", A_TMR, 32'h0);
    step();
    rd("post_rst_tmr2", A_TMR, 32'h1);
    rd("post_unmapped", BASE + 32'h20, 32'h0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
